riscv_branch_ctrl: RTL
======================

RISCV_BRANCH_CTRL -- requirements
Module: riscv_branch_ctrl

Interface
REQ-001 SHALL have i_riscv_brctrl_clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have i_riscv_brctrl_rst_n  in  1  reset, synchronous and active-low.
REQ-003 SHALL have i_riscv_brctrl_ex_valid  in  1  execute stage presents a branch.
REQ-004 SHALL have o_riscv_brctrl_ex_ready  out  1  controller can accept a branch.
REQ-005 SHALL have i_riscv_brctrl_ex_cond  in  4  branch condition code (BEQ=0, BNE=1, BLT=2, BGE=3, BLTU=4, BGEU=5).
REQ-006 SHALL have i_riscv_brctrl_ex_rs1data and i_riscv_brctrl_ex_rs2data  in  64 each  operands.
REQ-007 SHALL have i_riscv_brctrl_ex_pc and i_riscv_brctrl_ex_imm  in  64 each  branch PC and sign-extended offset.
REQ-008 SHALL have i_riscv_brctrl_ex_pred  in  1  direction predicted at fetch.
REQ-009 SHALL have o_riscv_brctrl_cmp_cond (4), o_riscv_brctrl_cmp_rs1data (64), o_riscv_brctrl_cmp_rs2data (64)  out  drive the branch comparator.
REQ-010 SHALL have i_riscv_brctrl_cmp_taken  in  1  comparator result.
REQ-011 SHALL have o_riscv_brctrl_redir_valid  out  1, o_riscv_brctrl_redir_pc  out  64, and i_riscv_brctrl_redir_ack  in  1  fetch redirect handshake.
REQ-012 SHALL have o_riscv_brctrl_flush  out  1  one-cycle pipeline flush pulse.
REQ-013 SHALL have i_riscv_brctrl_fetch_pc  in  64 and o_riscv_brctrl_fetch_pred  out  1  prediction lookup.
REQ-014 SHALL have o_riscv_brctrl_mispred_cnt  out  32  mispredict counter.

Function
REQ-015 SHALL implement FSM states IDLE, EVAL, REDIRECT.
REQ-016 In IDLE, ex_ready SHALL be 1; ex_valid&ex_ready SHALL latch cond/rs1/rs2/pc/imm/pred and move to EVAL.
REQ-017 In EVAL and REDIRECT, ex_ready SHALL be 0.
REQ-018 In EVAL, cmp_* outputs SHALL equal the latched values; in other states they SHALL be 0.
REQ-019 In EVAL, the block SHALL sample cmp_taken; cond codes 6-15 SHALL be forced to not-taken regardless of cmp_taken.
REQ-020 Resolved target SHALL be taken ? pc+imm : pc+4, modulo 2^64 (wrap, no overflow flag).
REQ-021 If taken != latched pred, the next state SHALL be REDIRECT, flush SHALL be 1 for exactly the first REDIRECT cycle, redir_valid SHALL be 1, and redir_pc SHALL be the target; otherwise the next state SHALL be IDLE with no flush.
REQ-022 Accept-to-flush latency SHALL be 2 cycles: accept edge, EVAL cycle, flush visible in the following cycle.
REQ-023 redir_valid and redir_pc SHALL hold stable until redir_ack; ack in the first REDIRECT cycle SHALL return the FSM to IDLE on the next edge.
REQ-024 redir_ack SHALL be ignored outside REDIRECT.
REQ-025 mispred_cnt SHALL increment by 1 per mispredict and saturate at 0xFFFF_FFFF.

Reset
REQ-026 Reset SHALL be sampled only on the clock edge; with rst_n=0 the FSM SHALL go to IDLE, all outputs SHALL be 0 except ex_ready=1, mispred_cnt SHALL be 0, and all BHT entries SHALL be weakly-not-taken (2'b01).
REQ-027 Reset in EVAL or REDIRECT SHALL abandon the branch without a flush or redirect.

Configuration
REQ-028 With RISCV_BRCTRL_BHT_EN defined, the block SHALL contain a 16-entry 2-bit saturating-counter BHT indexed by pc[5:2].
  - fetch_pred SHALL be combinational counter[1] at fetch_pc[5:2].
  - In EVAL, the entry at the latched pc[5:2] SHALL be incremented if taken and decremented if not taken, saturating at 3 and 0.
REQ-029 Without RISCV_BRCTRL_BHT_EN, fetch_pred SHALL be constant 0 (static not-taken), and no BHT storage SHALL exist.

Structure
REQ-030 The branch condition enum, FSM state enum, and the BHT depth/index constants SHALL live in shared package riscv_pkg.
REQ-031 The BHT SHALL be a sub-module riscv_bht instantiated only under RISCV_BRCTRL_BHT_EN.

Verification
REQ-032 BEQ with rs1=rs2=5, pred=0, cmp_taken=1, pc=0x1000, imm=0x40 -> flush pulse 1 cycle, redir_pc=0x1040, mispred_cnt=1.
REQ-033 BNE with pred=0, cmp_taken=0, pc=0x2000 -> no flush, no redirect, back to IDLE after 1 EVAL cycle.
REQ-034 Mispredict with redir_ack held low for 5 cycles -> redir_valid and redir_pc stable for all 5 cycles, ex_ready=0; ack -> IDLE next cycle.
REQ-035 pc=0xFFFF_FFFF_FFFF_FFFC, not-taken, pred=1 -> redir_pc=0x0 (wrap-around).
REQ-036 rst_n=0 during REDIRECT -> next cycle redir_valid=0, flush=0, ex_ready=1, mispred_cnt=0.
REQ-037 BHT_EN: three taken branches at pc=0x10 -> fetch_pred at fetch_pc=0x10 becomes 1 after the first update and saturates at counter value 3; cond=7 -> treated as not-taken.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the branch controller: condition codes,
// FSM states and BHT geometry.
package riscv_pkg;

  typedef enum logic [3:0] {
    COND_BEQ  = 4'd0,
    COND_BNE  = 4'd1,
    COND_BLT  = 4'd2,
    COND_BGE  = 4'd3,
    COND_BLTU = 4'd4,
    COND_BGEU = 4'd5
  } br_cond_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EVAL     = 2'd1,
    ST_REDIRECT = 2'd2
  } br_state_e;

  localparam int BHT_DEPTH   = 16;
  localparam int BHT_IDX_W   = 4;
  localparam int BHT_IDX_LSB = 2;
  localparam logic [1:0] BHT_WEAK_NT = 2'b01;

  // Codes above BGEU are reserved and always resolve as not-taken.
  function automatic logic cond_supported(input logic [3:0] cond);
    return cond <= COND_BGEU;
  endfunction

endpackage

// File: rtl/riscv_branch_ctrl_if.sv
// Execute/comparator/fetch-side signal bundle of the branch controller.
// The controller uses the slave modport; the surrounding pipeline uses master.
interface riscv_branch_ctrl_if;
  logic        i_riscv_brctrl_ex_valid;
  logic        o_riscv_brctrl_ex_ready;
  logic [3:0]  i_riscv_brctrl_ex_cond;
  logic [63:0] i_riscv_brctrl_ex_rs1data;
  logic [63:0] i_riscv_brctrl_ex_rs2data;
  logic [63:0] i_riscv_brctrl_ex_pc;
  logic [63:0] i_riscv_brctrl_ex_imm;
  logic        i_riscv_brctrl_ex_pred;
  logic [3:0]  o_riscv_brctrl_cmp_cond;
  logic [63:0] o_riscv_brctrl_cmp_rs1data;
  logic [63:0] o_riscv_brctrl_cmp_rs2data;
  logic        i_riscv_brctrl_cmp_taken;
  logic        o_riscv_brctrl_redir_valid;
  logic [63:0] o_riscv_brctrl_redir_pc;
  logic        i_riscv_brctrl_redir_ack;
  logic        o_riscv_brctrl_flush;
  logic [63:0] i_riscv_brctrl_fetch_pc;
  logic        o_riscv_brctrl_fetch_pred;
  logic [31:0] o_riscv_brctrl_mispred_cnt;

  modport master (
    output i_riscv_brctrl_ex_valid, i_riscv_brctrl_ex_cond, i_riscv_brctrl_ex_rs1data,
           i_riscv_brctrl_ex_rs2data, i_riscv_brctrl_ex_pc, i_riscv_brctrl_ex_imm,
           i_riscv_brctrl_ex_pred, i_riscv_brctrl_cmp_taken, i_riscv_brctrl_redir_ack,
           i_riscv_brctrl_fetch_pc,
    input  o_riscv_brctrl_ex_ready, o_riscv_brctrl_cmp_cond, o_riscv_brctrl_cmp_rs1data,
           o_riscv_brctrl_cmp_rs2data, o_riscv_brctrl_redir_valid, o_riscv_brctrl_redir_pc,
           o_riscv_brctrl_flush, o_riscv_brctrl_fetch_pred, o_riscv_brctrl_mispred_cnt
  );

  modport slave (
    input  i_riscv_brctrl_ex_valid, i_riscv_brctrl_ex_cond, i_riscv_brctrl_ex_rs1data,
           i_riscv_brctrl_ex_rs2data, i_riscv_brctrl_ex_pc, i_riscv_brctrl_ex_imm,
           i_riscv_brctrl_ex_pred, i_riscv_brctrl_cmp_taken, i_riscv_brctrl_redir_ack,
           i_riscv_brctrl_fetch_pc,
    output o_riscv_brctrl_ex_ready, o_riscv_brctrl_cmp_cond, o_riscv_brctrl_cmp_rs1data,
           o_riscv_brctrl_cmp_rs2data, o_riscv_brctrl_redir_valid, o_riscv_brctrl_redir_pc,
           o_riscv_brctrl_flush, o_riscv_brctrl_fetch_pred, o_riscv_brctrl_mispred_cnt
  );
endinterface

// File: rtl/riscv_bht.sv
// 16-entry table of 2-bit saturating direction counters with a combinational
// lookup port and one update port; every entry resets to weakly-not-taken.
module riscv_bht
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BHT_IDX_W-1:0] lookup_idx,
  output logic                 lookup_pred,
  input  logic                 upd_en,
  input  logic [BHT_IDX_W-1:0] upd_idx,
  input  logic                 upd_taken
);

  logic [2*BHT_DEPTH-1:0] ctr_flat;

  generate
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_entry
      logic [1:0] ctr_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ctr_reg <= BHT_WEAK_NT;
        end else if (upd_en && (upd_idx == BHT_IDX_W'(gi))) begin
          if (upd_taken && (ctr_reg != 2'b11)) begin
            ctr_reg <= ctr_reg + 2'd1;
          end else if (!upd_taken && (ctr_reg != 2'b00)) begin
            ctr_reg <= ctr_reg - 2'd1;
          end
        end
      end

      assign ctr_flat[2*gi +: 2] = ctr_reg;
    end
  endgenerate

  // The prediction is the MSB of the selected counter.
  assign lookup_pred = ctr_flat[{lookup_idx, 1'b1}];

endmodule

// File: rtl/riscv_branch_ctrl.sv
// Branch resolution controller: accepts a branch, drives the comparator for one
// cycle, and on mispredict flushes and holds a fetch redirect until acked.
// Optional BHT direction predictor enabled by defining RISCV_BRCTRL_BHT_EN.
module riscv_branch_ctrl
  import riscv_pkg::*;
(
  input  logic               i_riscv_brctrl_clk,
  input  logic               i_riscv_brctrl_rst_n,
  riscv_branch_ctrl_if.slave bus
);

  br_state_e   state_reg, state_next;
  logic [3:0]  cond_reg;
  logic [63:0] rs1_reg, rs2_reg, pc_reg, imm_reg, target_reg, target_next;
  logic        pred_reg, flush_first_reg, taken, mispred, accept;
  logic [31:0] cnt_reg;

  assign accept      = (state_reg == ST_IDLE) && bus.i_riscv_brctrl_ex_valid;
  assign taken       = bus.i_riscv_brctrl_cmp_taken && cond_supported(cond_reg);
  assign target_next = taken ? (pc_reg + imm_reg) : (pc_reg + 64'd4);
  assign mispred     = (taken != pred_reg);

  always_ff @(posedge i_riscv_brctrl_clk) begin
    if (!i_riscv_brctrl_rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (bus.i_riscv_brctrl_ex_valid) state_next = ST_EVAL;
      ST_EVAL:     state_next = mispred ? ST_REDIRECT : ST_IDLE;
      ST_REDIRECT: if (bus.i_riscv_brctrl_redir_ack) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_riscv_brctrl_clk) begin
    if (!i_riscv_brctrl_rst_n) begin
      cond_reg        <= 4'd0;
      rs1_reg         <= 64'd0;
      rs2_reg         <= 64'd0;
      pc_reg          <= 64'd0;
      imm_reg         <= 64'd0;
      pred_reg        <= 1'b0;
      target_reg      <= 64'd0;
      flush_first_reg <= 1'b0;
      cnt_reg         <= 32'd0;
    end else begin
      if (accept) begin
        cond_reg <= bus.i_riscv_brctrl_ex_cond;
        rs1_reg  <= bus.i_riscv_brctrl_ex_rs1data;
        rs2_reg  <= bus.i_riscv_brctrl_ex_rs2data;
        pc_reg   <= bus.i_riscv_brctrl_ex_pc;
        imm_reg  <= bus.i_riscv_brctrl_ex_imm;
        pred_reg <= bus.i_riscv_brctrl_ex_pred;
      end
      if (state_reg == ST_EVAL) begin
        target_reg <= target_next;
      end
      // Set only on the EVAL->REDIRECT edge, so flush lasts exactly one cycle.
      flush_first_reg <= (state_reg == ST_EVAL) && mispred;
      if ((state_reg == ST_EVAL) && mispred && (cnt_reg != 32'hFFFF_FFFF)) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  always_comb begin
    bus.o_riscv_brctrl_ex_ready    = 1'b0;
    bus.o_riscv_brctrl_cmp_cond    = 4'd0;
    bus.o_riscv_brctrl_cmp_rs1data = 64'd0;
    bus.o_riscv_brctrl_cmp_rs2data = 64'd0;
    bus.o_riscv_brctrl_redir_valid = 1'b0;
    bus.o_riscv_brctrl_redir_pc    = 64'd0;
    bus.o_riscv_brctrl_flush       = 1'b0;
    case (state_reg)
      ST_IDLE: bus.o_riscv_brctrl_ex_ready = 1'b1;
      ST_EVAL: begin
        bus.o_riscv_brctrl_cmp_cond    = cond_reg;
        bus.o_riscv_brctrl_cmp_rs1data = rs1_reg;
        bus.o_riscv_brctrl_cmp_rs2data = rs2_reg;
      end
      ST_REDIRECT: begin
        bus.o_riscv_brctrl_redir_valid = 1'b1;
        bus.o_riscv_brctrl_redir_pc    = target_reg;
        bus.o_riscv_brctrl_flush       = flush_first_reg;
      end
      default: bus.o_riscv_brctrl_ex_ready = 1'b0;
    endcase
  end

  assign bus.o_riscv_brctrl_mispred_cnt = cnt_reg;

`ifdef RISCV_BRCTRL_BHT_EN
  logic fetch_pred_bht;
  logic unused_fetch_bits;

  riscv_bht u_bht (
    .clk         (i_riscv_brctrl_clk),
    .rst_n       (i_riscv_brctrl_rst_n),
    .lookup_idx  (bus.i_riscv_brctrl_fetch_pc[BHT_IDX_LSB +: BHT_IDX_W]),
    .lookup_pred (fetch_pred_bht),
    .upd_en      (state_reg == ST_EVAL),
    .upd_idx     (pc_reg[BHT_IDX_LSB +: BHT_IDX_W]),
    .upd_taken   (taken)
  );

  assign bus.o_riscv_brctrl_fetch_pred = fetch_pred_bht;
  assign unused_fetch_bits = ^{bus.i_riscv_brctrl_fetch_pc[63:BHT_IDX_LSB+BHT_IDX_W],
                               bus.i_riscv_brctrl_fetch_pc[BHT_IDX_LSB-1:0]};
`else
  // Static not-taken: the fetch PC is not looked at.
  logic unused_fetch_bits;
  assign bus.o_riscv_brctrl_fetch_pred = 1'b0;
  assign unused_fetch_bits = ^bus.i_riscv_brctrl_fetch_pc;
`endif

endmodule
